// File: rtl/tset_pkg.sv
// Shared types and constants for the clock time-setting controller:
// FSM state encoding, field-select codes, field limits and the wrapping step helper.
package tset_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOU,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOU  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam logic [5:0] HOU_MAX    = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  localparam int BLINK_HALF_MS = 250;

  // One step up or down with wrap-around at 0 and max; no carry into other fields.
  function automatic logic [5:0] step_wrap(input logic [5:0] val,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) return (val >= max) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bus between the time-setting controller (master) and the timekeeper (slave):
// current time in, edited time, load strobe and count-hold out.
interface time_set_ctrl_if;

  logic [5:0] hou_cur;
  logic [5:0] min_cur;
  logic [5:0] sec_cur;
  logic [5:0] hou_temp;
  logic [5:0] min_temp;
  logic [5:0] sec_temp;
  logic       load;
  logic       stop_clk;

  modport master (
    input  hou_cur, min_cur, sec_cur,
    output hou_temp, min_temp, sec_temp, load, stop_clk
  );

  modport slave (
    output hou_cur, min_cur, sec_cur,
    input  hou_temp, min_temp, sec_temp, load, stop_clk
  );

endinterface

// File: rtl/time_set_ctrl_key_debounce.sv
// Push-key conditioner: 2-FF synchroniser, debounce counter on a 1 ms tick,
// debounced level and a one-cycle press pulse on each accepted 0->1 change.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_press;
  logic [DW-1:0] r_cnt;
  logic          w_accept;

  // A change is accepted once the synchronised level has differed for DEBOUNCE_MS ticks.
  assign w_accept = i_tick && (r_sync != r_level) && (r_cnt == DW'(DEBOUNCE_MS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_key;
      r_sync  <= r_meta;
      r_press <= w_accept && r_sync;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync;
      end else if (i_tick) begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Key-driven hour/minute/second setting controller for the 24 h clock.
// Optional auto-repeat on held inc/dec keys is built when TSET_AUTOREPEAT_EN is defined.
module time_set_ctrl
  import tset_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_S       = 10
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             key_mode,
  input  logic             key_inc,
  input  logic             key_dec,
  time_set_ctrl_if.master  tk,
  output logic [1:0]       sel,
  output logic             blink
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_TICKS = TIMEOUT_S * 1000;
  localparam int OW       = $clog2(TO_TICKS + 1);
  localparam int BW       = $clog2(BLINK_HALF_MS);

  state_e        r_state;
  state_e        w_next;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [OW-1:0] r_to_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_stop_clk;
  logic [5:0]    r_hou;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          w_lvl_mode, w_lvl_inc, w_lvl_dec;
  logic          w_press_mode, w_press_inc, w_press_dec;
  logic          w_mode_ev, w_inc_ev, w_dec_ev, w_any_ev;
  logic          w_in_set;
  logic          w_timeout;
  logic          w_unused;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
    .clk(clk_50Mhz), .rst(rst), .i_tick(w_tick), .i_key(key_mode),
    .o_level(w_lvl_mode), .o_press(w_press_mode)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
    .clk(clk_50Mhz), .rst(rst), .i_tick(w_tick), .i_key(key_inc),
    .o_level(w_lvl_inc), .o_press(w_press_inc)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_dec (
    .clk(clk_50Mhz), .rst(rst), .i_tick(w_tick), .i_key(key_dec),
    .o_level(w_lvl_dec), .o_press(w_press_dec)
  );

  // The mode level is never needed, and the inc/dec levels only feed auto-repeat.
  assign w_unused = w_lvl_mode ^ w_lvl_inc ^ w_lvl_dec ^ (REPEAT_DELAY_MS > REPEAT_RATE_MS);

  assign w_in_set  = (r_state == SET_HOU) || (r_state == SET_MIN) || (r_state == SET_SEC);
  assign w_mode_ev = w_press_mode;

`ifdef TSET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_armed;
  logic          r_rep_inc;
  logic          r_rep_dec;
  logic          w_rep_hold;
  logic          w_rep_fire;

  // First repeat after the delay, then one per rate period; both keys held means no repeat.
  assign w_rep_hold = w_in_set && (w_lvl_inc ^ w_lvl_dec);
  assign w_rep_fire = w_rep_hold && w_tick &&
                      (r_rep_cnt == (r_rep_armed ? RW'(REPEAT_RATE_MS - 1)
                                                 : RW'(REPEAT_DELAY_MS - 1)));

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_inc   <= 1'b0;
      r_rep_dec   <= 1'b0;
    end else begin
      r_rep_inc <= w_rep_fire && w_lvl_inc;
      r_rep_dec <= w_rep_fire && w_lvl_dec;
      if (!w_rep_hold) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else if (w_tick) begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign w_inc_ev = w_press_inc || r_rep_inc;
  assign w_dec_ev = w_press_dec || r_rep_dec;
`else
  assign w_inc_ev = w_press_inc;
  assign w_dec_ev = w_press_dec;
`endif

  assign w_any_ev  = w_mode_ev || w_inc_ev || w_dec_ev;
  assign w_timeout = w_in_set && (r_to_cnt == OW'(TO_TICKS));

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst)                        r_to_cnt <= '0;
    else if (!w_in_set || w_any_ev) r_to_cnt <= '0;
    else if (w_tick && !w_timeout)  r_to_cnt <= r_to_cnt + OW'(1);
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (w_mode_ev) w_next = SET_HOU;
      SET_HOU: if (w_mode_ev) w_next = SET_MIN; else if (w_timeout) w_next = RUN;
      SET_MIN: if (w_mode_ev) w_next = SET_SEC; else if (w_timeout) w_next = RUN;
      SET_SEC: if (w_mode_ev) w_next = COMMIT;  else if (w_timeout) w_next = RUN;
      COMMIT:  w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    sel     = SEL_NONE;
    tk.load = 1'b0;
    case (r_state)
      SET_HOU: sel     = SEL_HOU;
      SET_MIN: sel     = SEL_MIN;
      SET_SEC: sel     = SEL_SEC;
      COMMIT:  tk.load = 1'b1;
      default: ;
    endcase
  end

  // Registered from the next state so the hold request moves on the same edge as the state.
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) r_stop_clk <= 1'b0;
    else     r_stop_clk <= (w_next != RUN);
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_state == RUN) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_in_set && w_tick) begin
      if (r_blink_cnt == BW'(BLINK_HALF_MS - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Mode has priority over inc/dec; simultaneous inc and dec cancel out.
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_hou <= '0;
      r_min <= '0;
      r_sec <= '0;
    end else if ((r_state == RUN) && w_mode_ev) begin
      r_hou <= tk.hou_cur;
      r_min <= tk.min_cur;
      r_sec <= tk.sec_cur;
    end else if (w_in_set && !w_mode_ev && (w_inc_ev ^ w_dec_ev)) begin
      case (r_state)
        SET_HOU: r_hou <= step_wrap(r_hou, HOU_MAX, w_inc_ev);
        SET_MIN: r_min <= step_wrap(r_min, MINSEC_MAX, w_inc_ev);
        SET_SEC: r_sec <= step_wrap(r_sec, MINSEC_MAX, w_inc_ev);
        default: ;
      endcase
    end
  end

  assign tk.hou_temp = r_hou;
  assign tk.min_temp = r_min;
  assign tk.sec_temp = r_sec;
  assign tk.stop_clk = r_stop_clk;
  assign blink       = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: key-press vector table plus hand sequences for
// glitch rejection, commit timing, timeout, blink, async reset and optional auto-repeat.
module tb_time_set_ctrl;

  logic       clk;
  logic       rst;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [1:0] sel;
  logic       blink;

  time_set_ctrl_if tk ();

  time_set_ctrl #(
    .CLK_HZ(1000), .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(5), .TIMEOUT_S(1)
  ) dut (
    .clk_50Mhz(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .tk(tk), .sel(sel), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic m, i, d;
    int   ch, cm, cs;
    int   e_sel, e_h, e_m, e_s, e_stop, e_loads;
  } vec_t;

  vec_t vecs[19];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_loads = 0;
  int   last_h  = -1;
  int   last_m  = -1;
  int   last_s  = -1;
  int   seen;

  always @(negedge clk) begin
    if (tk.load === 1'b1) begin
      n_loads++;
      last_h = int'(tk.hou_temp);
      last_m = int'(tk.min_temp);
      last_s = int'(tk.sec_temp);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold the given keys for 'hold' cycles, release, then let debounce and FSM settle.
  task automatic press(input logic m, input logic i, input logic d, input int hold);
    key_mode = m;
    key_inc  = i;
    key_dec  = d;
    repeat (hold) @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    tk.hou_cur = 6'(h);
    tk.min_cur = 6'(m);
    tk.sec_cur = 6'(s);
  endtask

  initial begin
    //          m     i     d     ch  cm  cs  sel h   m   s   stp lds
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 12, 34, 56, 0,  0,  0,  0,  0,  0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 12, 34, 56, 1,  12, 34, 56, 1,  0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 12, 34, 56, 2,  12, 34, 56, 1,  0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 12, 34, 56, 3,  12, 34, 56, 1,  0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 12, 34, 56, 0,  12, 34, 56, 0,  1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 23, 0,  45, 1,  23, 0,  45, 1,  1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 23, 0,  45, 1,  0,  0,  45, 1,  1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 23, 0,  45, 1,  23, 0,  45, 1,  1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 23, 0,  45, 2,  23, 0,  45, 1,  1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 23, 0,  45, 2,  23, 59, 45, 1,  1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 23, 0,  45, 2,  23, 0,  45, 1,  1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 23, 0,  45, 3,  23, 0,  45, 1,  1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 23, 0,  45, 3,  23, 0,  45, 1,  1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 23, 0,  45, 3,  23, 0,  44, 1,  1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 23, 0,  45, 0,  23, 0,  44, 0,  2};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 23, 0,  45, 1,  23, 0,  45, 1,  2};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 23, 0,  45, 2,  23, 0,  45, 1,  2};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 23, 0,  45, 2,  23, 1,  45, 1,  2};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 23, 0,  45, 3,  23, 1,  45, 1,  2};

    rst      = 1'b1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    set_cur(12, 34, 56);
    repeat (3) @(negedge clk);
    check("reset sel", int'(sel), 0);
    check("reset load", int'(tk.load), 0);
    check("reset stop_clk", int'(tk.stop_clk), 0);
    check("reset blink", int'(blink), 0);
    check("reset hou_temp", int'(tk.hou_temp), 0);
    check("reset min_temp", int'(tk.min_temp), 0);
    check("reset sec_temp", int'(tk.sec_temp), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      set_cur(vecs[i].ch, vecs[i].cm, vecs[i].cs);
      press(vecs[i].m, vecs[i].i, vecs[i].d, 6);
      check($sformatf("v%0d sel", i), int'(sel), vecs[i].e_sel);
      check($sformatf("v%0d hou", i), int'(tk.hou_temp), vecs[i].e_h);
      check($sformatf("v%0d min", i), int'(tk.min_temp), vecs[i].e_m);
      check($sformatf("v%0d sec", i), int'(tk.sec_temp), vecs[i].e_s);
      check($sformatf("v%0d stop_clk", i), int'(tk.stop_clk), vecs[i].e_stop);
      check($sformatf("v%0d loads", i), n_loads, vecs[i].e_loads);
    end
    check("load2 hou", last_h, 23);
    check("load2 min", last_m, 0);
    check("load2 sec", last_s, 44);

    // Glitch rejection in SET_SEC: 2-cycle pulse ignored, 5-cycle hold counts once.
    key_inc = 1'b1;
    repeat (2) @(negedge clk);
    key_inc = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch sec", int'(tk.sec_temp), 45);
    press(1'b0, 1'b1, 1'b0, 5);
    check("hold5 sec", int'(tk.sec_temp), 46);
    check("hold5 min", int'(tk.min_temp), 1);

    // Commit timing: load for exactly one cycle with stop_clk still high, then both low.
    seen     = 0;
    key_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (seen == 1) begin
        check("commit after load", int'(tk.load), 0);
        check("commit after stop_clk", int'(tk.stop_clk), 0);
        seen = 2;
      end else if (seen == 0 && tk.load === 1'b1) begin
        check("commit stop_clk", int'(tk.stop_clk), 1);
        check("commit sel", int'(sel), 0);
        seen = 1;
      end
      if (k == 5) key_mode = 1'b0;
    end
    check("commit load seen", seen, 2);
    check("load3 count", n_loads, 3);
    check("load3 hou", last_h, 23);
    check("load3 min", last_m, 1);
    check("load3 sec", last_s, 46);

    // Timeout: SET_MIN with no keys returns to RUN after 1000 ticks without a load.
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    check("timeout entry sel", int'(sel), 2);
    repeat (980) @(negedge clk);
    check("timeout early sel", int'(sel), 2);
    check("timeout early stop_clk", int'(tk.stop_clk), 1);
    repeat (20) @(negedge clk);
    check("timeout sel", int'(sel), 0);
    check("timeout stop_clk", int'(tk.stop_clk), 0);
    check("timeout loads", n_loads, 3);
    check("timeout hou kept", int'(tk.hou_temp), 23);

    // Blink and async reset while in SET_SEC.
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    check("rst pre sel", int'(sel), 3);
    check("blink low early", int'(blink), 0);
    repeat (250) @(negedge clk);
    check("blink toggled", int'(blink), 1);
    #2 rst = 1'b1;
    #1;
    check("async rst sel", int'(sel), 0);
    check("async rst stop_clk", int'(tk.stop_clk), 0);
    check("async rst load", int'(tk.load), 0);
    check("async rst blink", int'(blink), 0);
    check("async rst hou", int'(tk.hou_temp), 0);
    check("async rst min", int'(tk.min_temp), 0);
    check("async rst sec", int'(tk.sec_temp), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post rst loads", n_loads, 3);
    check("post rst sel", int'(sel), 0);

`ifdef TSET_AUTOREPEAT_EN
    // Auto-repeat: press at debounce, repeats 10 ms later and then every 5 ms while held.
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    check("rep sel", int'(sel), 2);
    key_inc = 1'b1;
    repeat (32) @(negedge clk);
    key_inc = 1'b0;
    repeat (15) @(negedge clk);
    check("rep min", int'(tk.min_temp), 6);
    check("rep hou", int'(tk.hou_temp), 23);
    check("rep sec", int'(tk.sec_temp), 45);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
